// File: rtl/bcdtobin_seq.sv
// Sequential BCD-to-binary converter.
// Four packed BCD digits are converted with reverse double-dabble, one bit
// per clock, behind a start/busy/done handshake. Illegal digits (>9) are
// flagged through err and skip the shift phase.
module bcdtobin_seq #(
    parameter int DIGITS = 4,
    parameter int BIN_W  = 14
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [3:0]       one,
    input  logic [3:0]       ten,
    input  logic [3:0]       hun,
    input  logic [3:0]       tho,
    output logic [BIN_W-1:0] bin,
    output logic             busy,
    output logic             done,
    output logic             err
);

    localparam int BCD_W = 4 * DIGITS;
    localparam int CNT_W = $clog2(BIN_W);
    localparam logic [CNT_W-1:0] LAST_STEP = CNT_W'(BIN_W - 1);

    typedef enum logic [1:0] {
        IDLE,
        SHIFT,
        FIN
    } state_t;

    state_t             r_state;
    state_t             w_nextState;
    logic [BCD_W-1:0]   r_bcd;
    logic [BIN_W-1:0]   r_binReg;
    logic [CNT_W-1:0]   r_cnt;
    logic               r_bad;

    logic [BCD_W-1:0]   w_inBcd;
    logic               w_inBad;
    logic [BCD_W-1:0]   w_shiftBcd;
    logic [BCD_W-1:0]   w_adjBcd;
    logic [BIN_W-1:0]   w_shiftBin;

    assign w_inBcd = {tho, hun, ten, one};

    // Flag the request as bad if any captured digit is above 9.
    always_comb begin
        w_inBad = 1'b0;
        for (int d = 0; d < DIGITS; d++) begin
            if (w_inBcd[4*d +: 4] > 4'd9) begin
                w_inBad = 1'b1;
            end
        end
    end

    // One reverse double-dabble step: shift {bcd, bin} right, then pull every
    // digit that reached 8 or more back down by 3.
    always_comb begin
        w_shiftBcd = r_bcd >> 1;
        w_shiftBin = {r_bcd[0], r_binReg[BIN_W-1:1]};
        w_adjBcd   = w_shiftBcd;
        for (int d = 0; d < DIGITS; d++) begin
            if (w_shiftBcd[4*d +: 4] >= 4'd8) begin
                w_adjBcd[4*d +: 4] = w_shiftBcd[4*d +: 4] - 4'd3;
            end
        end
    end

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_nextState;
        end
    end

    // Next-state logic: bad input bypasses the shift phase entirely.
    always_comb begin
        w_nextState = r_state;
        case (r_state)
            IDLE: begin
                if (start) begin
                    w_nextState = w_inBad ? FIN : SHIFT;
                end
            end
            SHIFT: begin
                if (r_cnt == LAST_STEP) begin
                    w_nextState = FIN;
                end
            end
            FIN: begin
                w_nextState = IDLE;
            end
            default: begin
                w_nextState = IDLE;
            end
        endcase
    end

    // Output logic: busy covers every cycle spent outside IDLE.
    always_comb begin
        busy = (r_state != IDLE);
    end

    // Datapath: capture on start, step during SHIFT, publish the result in FIN.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_bcd    <= '0;
            r_binReg <= '0;
            r_cnt    <= '0;
            r_bad    <= 1'b0;
            bin      <= '0;
            done     <= 1'b0;
            err      <= 1'b0;
        end else begin
            done <= 1'b0;
            case (r_state)
                IDLE: begin
                    if (start) begin
                        r_bcd    <= w_inBcd;
                        r_binReg <= '0;
                        r_cnt    <= '0;
                        r_bad    <= w_inBad;
                    end
                end
                SHIFT: begin
                    r_bcd    <= w_adjBcd;
                    r_binReg <= w_shiftBin;
                    r_cnt    <= r_cnt + CNT_W'(1);
                end
                FIN: begin
                    bin  <= r_bad ? '0 : r_binReg;
                    err  <= r_bad;
                    done <= 1'b1;
                end
                default: begin
                    done <= 1'b0;
                end
            endcase
        end
    end

    // A legal conversion must have drained every BCD digit by the time it finishes.
    assert property (@(posedge clk) disable iff (!rst_n)
        (r_state == FIN && !r_bad) |-> (r_bcd == '0));

endmodule
